// File: rtl/murax_uart_tx_arbiter.sv
// murax_uart_tx_arbiter
//
// Shares the board's single UART TX pad between two serial transmitters:
// the Murax UART (src0) and an auxiliary status/debug transmitter (src1).
// A baud-period counter follows the frame of whichever source owns the
// line. Ownership only changes while the line is idle, so a character is
// never cut in half. After each frame the owner keeps the line for a short
// idle gap, so multi-byte messages sent back-to-back stay together.
//
// Ports:
//   io_mainClk      in   1  sole clock, rising edge
//   io_asyncResetn  in   1  asynchronous active-low reset
//   io_src0_txd     in   1  Murax UART txd (idle high, asynchronous)
//   io_src1_txd     in   1  auxiliary txd (idle high, asynchronous)
//   io_txd          out  1  registered arbitrated line to the pad
//   io_grant        out  2  one-hot owner (01 src0, 10 src1, 00 none)
//   io_busy         out  1  high while a frame or its trailing gap is owned
//   io_collision    out  1  one-cycle pulse: non-owner started and was dropped
//   io_frameError   out  1  one-cycle pulse: stop bit sampled low

module murax_uart_tx_arbiter #(
    parameter int CLK_HZ    = 12000000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int GAP_BITS  = 2
) (
    input  logic       io_mainClk,
    input  logic       io_asyncResetn,
    input  logic       io_src0_txd,
    input  logic       io_src1_txd,
    output logic       io_txd,
    output logic [1:0] io_grant,
    output logic       io_busy,
    output logic       io_collision,
    output logic       io_frameError
);

    // Clocks per bit and the two counter targets derived from it.
    localparam int CPB         = CLK_HZ / BAUD;
    localparam int STOP_SAMPLE = (1 + DATA_BITS) * CPB + CPB / 2;
    localparam int GAP_LAST    = GAP_BITS * CPB - 1;
    localparam int CNT_W       = $clog2(STOP_SAMPLE) + 1;
    localparam int GAP_W       = $clog2(GAP_LAST) + 1;

    localparam logic [CNT_W-1:0] STOP_SAMPLE_C = CNT_W'(STOP_SAMPLE);
    localparam logic [GAP_W-1:0] GAP_LAST_C    = GAP_W'(GAP_LAST);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Owner encoding: 0 = src0, 1 = src1.
    localparam logic OWN_SRC0 = 1'b0;
    localparam logic OWN_SRC1 = 1'b1;

    logic [1:0]       sync0;
    logic [1:0]       sync1;
    logic             s0;
    logic             s1;
    logic             s0_d;
    logic             s1_d;
    logic             start0;
    logic             start1;

    state_t           state;
    state_t           state_nx;
    logic             owner;
    logic             owner_nx;
    logic             last_grant;
    logic             last_grant_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [GAP_W-1:0] gap_cnt;
    logic [GAP_W-1:0] gap_cnt_nx;

    logic             granted_s;
    logic             granted_start;
    logic             other_start;

    logic             collision_nx;
    logic             frame_error_nx;
    logic             txd_nx;
    logic [1:0]       grant_nx;

    // Two-flop synchronizers plus one delay flop per source. The lines idle
    // high, so every stage resets to 1 and no false start is seen when reset
    // is released with the lines idle.
    always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
        if (!io_asyncResetn) begin
            sync0 <= 2'b11;
            sync1 <= 2'b11;
            s0_d  <= 1'b1;
            s1_d  <= 1'b1;
        end else begin
            sync0 <= {sync0[0], io_src0_txd};
            sync1 <= {sync1[0], io_src1_txd};
            s0_d  <= sync0[1];
            s1_d  <= sync1[1];
        end
    end

    assign s0     = sync0[1];
    assign s1     = sync1[1];
    assign start0 = s0_d & ~s0;
    assign start1 = s1_d & ~s1;

    // Views relative to the current owner; only meaningful outside IDLE.
    assign granted_s     = (owner == OWN_SRC1) ? s1 : s0;
    assign granted_start = (owner == OWN_SRC1) ? start1 : start0;
    assign other_start   = (owner == OWN_SRC1) ? start0 : start1;

    // State register together with the registered outputs. Every output
    // returns to its idle value the moment reset is asserted, truncating any
    // character in flight on the pad.
    always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
        if (!io_asyncResetn) begin
            state         <= IDLE;
            owner         <= OWN_SRC0;
            last_grant    <= OWN_SRC1;
            cnt           <= '0;
            gap_cnt       <= '0;
            io_txd        <= 1'b1;
            io_grant      <= 2'b00;
            io_busy       <= 1'b0;
            io_collision  <= 1'b0;
            io_frameError <= 1'b0;
        end else begin
            state         <= state_nx;
            owner         <= owner_nx;
            last_grant    <= last_grant_nx;
            cnt           <= cnt_nx;
            gap_cnt       <= gap_cnt_nx;
            io_txd        <= txd_nx;
            io_grant      <= grant_nx;
            io_busy       <= (state_nx != IDLE);
            io_collision  <= collision_nx;
            io_frameError <= frame_error_nx;
        end
    end

    // Next-state logic. A start is a falling edge of a synchronized line.
    // In IDLE the first start wins; a tie goes to whichever source did not
    // own the line last. In FRAME the counter runs to the middle of the stop
    // bit. In GAP the owner must hold the line high for GAP_BITS bit-times
    // before it is released; a new start from the owner restarts FRAME so
    // back-to-back characters keep the grant. Starts from the non-owner in
    // FRAME or GAP are dropped and flagged, including one that lands in the
    // very cycle the gap expires (it is an edge, so it cannot wait for IDLE).
    always_comb begin
        state_nx       = state;
        owner_nx       = owner;
        last_grant_nx  = last_grant;
        cnt_nx         = cnt;
        gap_cnt_nx     = gap_cnt;
        collision_nx   = 1'b0;
        frame_error_nx = 1'b0;

        case (state)
            IDLE: begin
                if (start0 && start1) begin
                    owner_nx     = ~last_grant;
                    state_nx     = FRAME;
                    cnt_nx       = '0;
                    collision_nx = 1'b1;
                end else if (start0) begin
                    owner_nx = OWN_SRC0;
                    state_nx = FRAME;
                    cnt_nx   = '0;
                end else if (start1) begin
                    owner_nx = OWN_SRC1;
                    state_nx = FRAME;
                    cnt_nx   = '0;
                end
            end

            FRAME: begin
                cnt_nx = cnt + CNT_W'(1);
                if (other_start) begin
                    collision_nx = 1'b1;
                end
                if (cnt == STOP_SAMPLE_C) begin
                    frame_error_nx = ~granted_s;
                    state_nx       = GAP;
                    gap_cnt_nx     = '0;
                end
            end

            GAP: begin
                if (other_start) begin
                    collision_nx = 1'b1;
                end
                if (granted_start) begin
                    state_nx = FRAME;
                    cnt_nx   = '0;
                end else if (granted_s) begin
                    if (gap_cnt == GAP_LAST_C) begin
                        state_nx      = IDLE;
                        last_grant_nx = owner;
                    end else begin
                        gap_cnt_nx = gap_cnt + GAP_W'(1);
                    end
                end else begin
                    gap_cnt_nx = '0;
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase

        // The pad follows the next owner so the start bit reaches the pad on
        // the same edge that the grant is taken.
        if (state_nx == IDLE) begin
            txd_nx   = 1'b1;
            grant_nx = 2'b00;
        end else if (owner_nx == OWN_SRC1) begin
            txd_nx   = s1;
            grant_nx = 2'b10;
        end else begin
            txd_nx   = s0;
            grant_nx = 2'b01;
        end
    end

endmodule

// File: tb/tb_murax_uart_tx_arbiter.sv
// tb_murax_uart_tx_arbiter
//
// Bench for murax_uart_tx_arbiter with CPB = 10, 8 data bits, 2 gap bits.
// Each segment lays out both source pin waveforms in arrays, derives the
// expected pad/grant/pulse timeline from the arbitration rules, then drives
// the pins cycle by cycle and compares every output in every cycle.

module tb_murax_uart_tx_arbiter;

    localparam int CPB     = 10;
    localparam int STOP_AT = (1 + 8) * CPB + CPB / 2;
    localparam int GAP_CYC = 2 * CPB;
    localparam int H       = 800;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       src0  = 1'b1;
    logic       src1  = 1'b1;
    logic       txd;
    logic [1:0] grant;
    logic       busy;
    logic       coll;
    logic       ferr;

    int n_asserts = 0;
    int n_fail    = 0;

    bit         pin0      [H];
    bit         pin1      [H];
    logic [1:0] exp_grant [H];
    bit         exp_txd   [H];
    bit         exp_coll  [H];
    bit         exp_ferr  [H];
    int         seg_len;
    int         last_owner;

    murax_uart_tx_arbiter #(
        .CLK_HZ    (1000000),
        .BAUD      (100000),
        .DATA_BITS (8),
        .GAP_BITS  (2)
    ) dut (
        .io_mainClk     (clk),
        .io_asyncResetn (rst_n),
        .io_src0_txd    (src0),
        .io_src1_txd    (src1),
        .io_txd         (txd),
        .io_grant       (grant),
        .io_busy        (busy),
        .io_collision   (coll),
        .io_frameError  (ferr)
    );

    always #5 clk = ~clk;

    // Line level the arbiter acts on in cycle c: the pin two cycles earlier.
    function automatic bit line_at(input int src, input int c);
        int p;
        p = c - 2;
        if (p < 0 || p >= H) return 1'b1;
        return (src == 0) ? pin0[p] : pin1[p];
    endfunction

    function automatic bit falls(input int src, input int c);
        return line_at(src, c - 1) & ~line_at(src, c);
    endfunction

    function automatic void clear_pins();
        for (int i = 0; i < H; i++) begin
            pin0[i] = 1'b1;
            pin1[i] = 1'b1;
        end
    endfunction

    // One 8N1 character starting at pin cycle t; a bad stop bit is low for
    // one bit-time and the line then returns high.
    function automatic void put_frame(input int src, input int t,
                                      input logic [7:0] data, input bit stop_ok);
        for (int k = 0; k < 10; k++) begin
            bit lvl;
            if (k == 0) lvl = 1'b0;
            else if (k <= 8) lvl = data[k-1];
            else lvl = stop_ok;
            for (int j = 0; j < CPB; j++) begin
                int p;
                p = t + k * CPB + j;
                if (p < H) begin
                    if (src == 0) pin0[p] = lvl;
                    else pin1[p] = lvl;
                end
            end
        end
    endfunction

    // Expected timeline. Scan for the next falling edge while idle; the
    // grant appears one cycle later. Each character is owned for 96 cycles
    // (stop bit judged at the 96th), then the owner needs 20 consecutive
    // high cycles to let go; a new owner edge inside that window starts
    // another character. The pad shows the owner's pin three cycles late.
    task automatic build_model();
        int c;
        int own;
        int g;
        int e;
        int run;
        int rel;
        int last_low;
        bit f0;
        bit f1;
        bit restart;
        last_low = 0;
        for (int i = 0; i < H; i++) begin
            exp_grant[i] = 2'b00;
            exp_txd[i]   = 1'b1;
            exp_coll[i]  = 1'b0;
            exp_ferr[i]  = 1'b0;
            if (!pin0[i] || !pin1[i]) last_low = i;
        end
        seg_len = (last_low + 8 > 20) ? last_low + 8 : 20;
        c = 0;
        while (c < H - 2) begin
            f0 = falls(0, c);
            f1 = falls(1, c);
            if (!f0 && !f1) begin
                c++;
            end else begin
                if (f0 && f1) begin
                    own = 1 - last_owner;
                    exp_coll[c+1] = 1'b1;
                end else begin
                    own = f0 ? 0 : 1;
                end
                g   = c + 1;
                rel = -1;
                while (rel < 0) begin
                    e = g + STOP_AT + 1;
                    if (e >= H - 1) begin
                        rel = H - 1;
                    end else begin
                        exp_ferr[e] = ~line_at(own, e - 1);
                        run     = 0;
                        restart = 1'b0;
                        while (rel < 0 && !restart) begin
                            if (e >= H - 1) begin
                                rel = H - 1;
                            end else if (falls(own, e)) begin
                                g       = e + 1;
                                restart = 1'b1;
                            end else if (line_at(own, e)) begin
                                run++;
                                if (run == GAP_CYC) rel = e + 1;
                                else e++;
                            end else begin
                                run = 0;
                                e++;
                            end
                        end
                    end
                end
                for (int x = c + 1; x < rel; x++) begin
                    exp_grant[x] = (own == 0) ? 2'b01 : 2'b10;
                    exp_txd[x]   = line_at(own, x - 1);
                    if (falls(1 - own, x) && x + 1 < H) exp_coll[x+1] = 1'b1;
                end
                last_owner = own;
                c = rel;
                if (rel + 10 > seg_len) seg_len = rel + 10;
            end
        end
        if (seg_len > H) seg_len = H;
    endtask

    task automatic checkOutput(input string tag, input int c,
                               input logic [1:0] obs, input logic [1:0] exp_v);
        n_asserts++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, c, obs, exp_v);
        end
    endtask

    task automatic check_reset_values(input string tag, input int c);
        checkOutput({tag, "_txd"},   c, {1'b0, txd},  2'b01);
        checkOutput({tag, "_grant"}, c, grant,        2'b00);
        checkOutput({tag, "_busy"},  c, {1'b0, busy}, 2'b00);
        checkOutput({tag, "_coll"},  c, {1'b0, coll}, 2'b00);
        checkOutput({tag, "_ferr"},  c, {1'b0, ferr}, 2'b00);
    endtask

    // Drive the prepared pins one cycle at a time and compare all outputs
    // mid-cycle against the expected timeline.
    task automatic applyStimulus(input int len);
        for (int c = 0; c < len; c++) begin
            @(posedge clk);
            #1;
            src0 = pin0[c];
            src1 = pin1[c];
            @(negedge clk);
            checkOutput("txd",   c, {1'b0, txd},  {1'b0, exp_txd[c]});
            checkOutput("grant", c, grant,        exp_grant[c]);
            checkOutput("busy",  c, {1'b0, busy}, {1'b0, (exp_grant[c] != 2'b00)});
            checkOutput("coll",  c, {1'b0, coll}, {1'b0, exp_coll[c]});
            checkOutput("ferr",  c, {1'b0, ferr}, {1'b0, exp_ferr[c]});
        end
    endtask

    initial begin
        int t;
        int t0;
        int t1;
        int p;

        last_owner = 1;
        rst_n = 1'b0;

        $display("[TB] reset held with toggling inputs");
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            src0 = 1'($urandom_range(0, 1));
            src1 = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_reset_values("rst_hold", i);
        end
        @(posedge clk);
        #1;
        src0 = 1'b1;
        src1 = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] idle after reset release");
        clear_pins();
        build_model();
        applyStimulus(seg_len);

        $display("[TB] simultaneous starts, twice");
        for (int rep = 0; rep < 2; rep++) begin
            clear_pins();
            t = 3 + $urandom_range(0, 5);
            put_frame(0, t, 8'hA5, 1'b1);
            put_frame(1, t, 8'hA5, 1'b1);
            build_model();
            applyStimulus(seg_len);
        end

        $display("[TB] src0 sends 0x55");
        clear_pins();
        t = 3 + $urandom_range(0, 5);
        put_frame(0, t, 8'h55, 1'b1);
        build_model();
        applyStimulus(seg_len);

        $display("[TB] src1 back-to-back with src0 collision, then src0 after gap");
        clear_pins();
        t = 5;
        put_frame(1, t, 8'h31, 1'b1);
        put_frame(1, t + 10 * CPB, 8'h32, 1'b1);
        put_frame(0, t + 30, 8'($urandom), 1'b1);
        p = t + 220 + $urandom_range(0, 4);
        put_frame(0, p, 8'($urandom), 1'b1);
        build_model();
        applyStimulus(seg_len);

        $display("[TB] src0 frame with low stop bit");
        clear_pins();
        t = 3 + $urandom_range(0, 5);
        put_frame(0, t, 8'($urandom), 1'b0);
        build_model();
        applyStimulus(seg_len);

        $display("[TB] randomized overlapping frames");
        for (int r = 0; r < 3; r++) begin
            clear_pins();
            t0 = $urandom_range(0, 150);
            t1 = ($urandom_range(0, 3) == 0) ? t0 : $urandom_range(0, 150);
            put_frame(0, t0, 8'($urandom), $urandom_range(0, 3) != 0);
            put_frame(1, t1, 8'($urandom), $urandom_range(0, 3) != 0);
            build_model();
            applyStimulus(seg_len);
        end

        $display("[TB] reset asserted mid-frame");
        clear_pins();
        t = 4;
        put_frame(0, t, 8'($urandom), 1'b1);
        build_model();
        applyStimulus(t + 3 + 40);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("rst_async", 0);
        src0 = 1'b1;
        src1 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        last_owner = 1;

        $display("[TB] src1 frame after mid-frame reset");
        clear_pins();
        put_frame(1, 5, 8'($urandom), 1'b1);
        build_model();
        applyStimulus(seg_len);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
